// File: rtl/lock_pkg.sv
// +------------------------------------------------------------------+
// | lock_pkg : state encodings shared by the code lock controller     |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package lock_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    LOCKED   = 3'd0,
    INPUT    = 3'd1,
    VERIFY   = 3'd2,
    ERROR    = 3'd3,
    UNLOCKED = 3'd4,
    LOCKOUT  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/lock_digit_buffer.sv
// +------------------------------------------------------------------+
// | lock_digit_buffer : indexed digit capture and compare vs code     |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module lock_digit_buffer #(
  parameter int DIGIT_W  = 4,
  parameter int CODE_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en_i,
  input  logic                        clr_i,
  input  logic [DIGIT_W-1:0]          digit_i,
  input  logic [CODE_LEN*DIGIT_W-1:0] code_i,
  output logic                        last_o,
  output logic                        match_o
);

  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  logic [CODE_LEN*DIGIT_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]            idx_q, idx_d;

  // Slot 0 is the first digit entered and lands in the MS slice, matching code_i.
  assign last_o  = (idx_q == IDX_W'(CODE_LEN - 1));
  assign match_o = (buf_q == code_i);

  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    if (clr_i) begin
      buf_d = '0;
      idx_d = '0;
    end else if (wr_en_i) begin
      buf_d[(CODE_LEN - 1 - int'(idx_q)) * DIGIT_W +: DIGIT_W] = digit_i;
      idx_d = last_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
      idx_q <= '0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/code_lock_fsm.sv
// +------------------------------------------------------------------+
// | code_lock_fsm : digit-entry lock controller with relock timer     |
// | Option   : CODE_LOCK_LOCKOUT_EN enables the LOCKOUT state         |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module code_lock_fsm
  import lock_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             digit_valid,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             clear,
  input  logic                             relock,
  input  logic [CODE_LEN*DIGIT_W-1:0]      code,
  output logic [STATE_W-1:0]               state,
  output logic                             unlocked,
  output logic                             error,
  output logic                             lockout,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

  localparam int FC_W    = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  logic [STATE_W-1:0] state_q;
  state_e             state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [FC_W-1:0]    fail_q, fail_d;
  logic               buf_wr, buf_clr, buf_last, buf_match;

  lock_digit_buffer #(
    .DIGIT_W  (DIGIT_W),
    .CODE_LEN (CODE_LEN)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en_i (buf_wr),
    .clr_i   (buf_clr),
    .digit_i (digit),
    .code_i  (code),
    .last_o  (buf_last),
    .match_o (buf_match)
  );

  always_comb begin
    state_d = LOCKED;
    fail_d  = fail_q;
    buf_wr  = 1'b0;
    case (state_q)
      LOCKED: begin
        if (digit_valid) begin
          buf_wr  = 1'b1;
          state_d = buf_last ? VERIFY : INPUT;
        end
      end
      INPUT: begin
        state_d = INPUT;
        if (clear) begin
          state_d = LOCKED;
        end else if (digit_valid) begin
          buf_wr = 1'b1;
          if (buf_last) state_d = VERIFY;
        end
      end
      VERIFY: begin
        if (buf_match) begin
          state_d = UNLOCKED;
          fail_d  = '0;
        end else begin
          state_d = ERROR;
          if (fail_q != FC_W'(MAX_TRIES)) fail_d = fail_q + 1'b1;
        end
      end
      ERROR: begin
`ifdef CODE_LOCK_LOCKOUT_EN
        state_d = (fail_q == FC_W'(MAX_TRIES)) ? LOCKOUT : LOCKED;
`else
        state_d = LOCKED;
`endif
      end
      UNLOCKED: begin
        state_d = UNLOCKED;
        if (relock || timer_q == TMR_W'(UNLOCK_CYCLES - 1)) state_d = LOCKED;
      end
`ifdef CODE_LOCK_LOCKOUT_EN
      LOCKOUT: begin
        state_d = LOCKOUT;
        if (timer_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
          state_d = LOCKED;
          fail_d  = '0;
        end
      end
`endif
      default: state_d = LOCKED;
    endcase
  end

  // Every path into LOCKED (and idling there) leaves the buffer empty.
  assign buf_clr = (state_d == LOCKED);

  // Shared dwell timer restarts on every state change.
  always_comb begin
    timer_d = '0;
    if ((state_q == UNLOCKED || state_q == LOCKOUT) && state_q == state_d)
      timer_d = timer_q + 1'b1;
  end

  for (genvar i = 0; i < STATE_W; i++) begin : g_state_dff
    logic bit_q;
    always_ff @(posedge clk) begin
      if (reset) bit_q <= 1'b0;
      else       bit_q <= state_d[i];
    end
    assign state_q[i] = bit_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      fail_q  <= '0;
    end else begin
      timer_q <= timer_d;
      fail_q  <= fail_d;
    end
  end

  assign state      = state_q;
  assign unlocked   = (state_q == UNLOCKED);
  assign error      = (state_q == ERROR);
  assign fail_count = fail_q;
`ifdef CODE_LOCK_LOCKOUT_EN
  assign lockout    = (state_q == LOCKOUT);
`else
  assign lockout    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_code_lock_fsm.sv
// +------------------------------------------------------------------+
// | tb_code_lock_fsm : directed self-checking bench for code_lock_fsm |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_code_lock_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        clear = 1'b0;
  logic        relock = 1'b0;
  logic [15:0] code = 16'h1234;
  logic [2:0]  state;
  logic        unlocked, error, lockout;
  logic [1:0]  fail_count;

  int errors = 0;
  int checks = 0;

  code_lock_fsm #(
    .DIGIT_W(4), .CODE_LEN(4), .MAX_TRIES(3), .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit), .clear(clear),
    .relock(relock), .code(code), .state(state), .unlocked(unlocked), .error(error),
    .lockout(lockout), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    cyc();
    digit_valid = 1'b0;
  endtask

  // Sends four digits, MS nibble first; the last edge leaves the DUT in VERIFY.
  task automatic enter_code(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    for (int i = 3; i >= 0; i--) send_digit(v[i*4 +: 4]);
  endtask

  task automatic do_relock();
    relock = 1'b1;
    cyc();
    relock = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    checks++;
    if (state !== 3'd0 || unlocked !== 1'b0 || error !== 1'b0 || lockout !== 1'b0 || fail_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d unl=%b err=%b lko=%b fc=%0d expected all 0",
               state, unlocked, error, lockout, fail_count);
    end
  endtask

  task automatic test_unlock();
    send_digit(4'd1);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL unlock_input: state=%0d expected 1", state); end
    send_digit(4'd2);
    cyc();
    send_digit(4'd3);
    send_digit(4'd4);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL unlock_verify: state=%0d expected 2", state); end
    cyc();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (unlocked !== 1'b1 || state !== 3'd4) begin
        errors++;
        $display("FAIL unlock_hold[%0d]: unl=%b state=%0d expected 1/4", i, unlocked, state);
      end
      digit_valid = (i == 3);
      digit       = 4'd1;
      cyc();
    end
    digit_valid = 1'b0;
    checks++;
    if (state !== 3'd0 || unlocked !== 1'b0) begin
      errors++;
      $display("FAIL unlock_expire: state=%0d unl=%b expected 0/0", state, unlocked);
    end
  endtask

  task automatic test_wrong_then_right();
    enter_code(16'h1235);
    cyc();
    checks++;
    if (error !== 1'b1 || state !== 3'd3 || fail_count !== 2'd1) begin
      errors++;
      $display("FAIL wrong_error: err=%b state=%0d fc=%0d expected 1/3/1", error, state, fail_count);
    end
    cyc();
    checks++;
    if (state !== 3'd0 || error !== 1'b0) begin
      errors++;
      $display("FAIL wrong_back_locked: state=%0d err=%b expected 0/0", state, error);
    end
    enter_code(16'h1234);
    cyc();
    checks++;
    if (unlocked !== 1'b1 || fail_count !== 2'd0) begin
      errors++;
      $display("FAIL right_after_wrong: unl=%b fc=%0d expected 1/0", unlocked, fail_count);
    end
    cyc();
    do_relock();
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL relock_cycle2: state=%0d expected 0", state); end
  endtask

  task automatic test_clear();
    send_digit(4'd1);
    send_digit(4'd2);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL clear_abort: state=%0d expected 0", state); end
    send_digit(4'd1);
    clear = 1'b1;
    send_digit(4'd9);
    clear = 1'b0;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL clear_priority: state=%0d expected 0", state); end
    enter_code(16'h1234);
    cyc();
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL clear_stale: unl=%b expected 1", unlocked); end
    do_relock();
  endtask

  task automatic test_code_sampling();
    send_digit(4'd5);
    send_digit(4'd6);
    send_digit(4'd7);
    code = 16'h5678;
    send_digit(4'd8);
    cyc();
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL code_in_verify: unl=%b expected 1", unlocked); end
    code = 16'h1234;
    do_relock();
  endtask

  task automatic test_max_tries();
    for (int i = 0; i < 3; i++) begin
      enter_code(16'h4321);
      cyc();
      checks++;
      if (error !== 1'b1 || fail_count !== 2'(i + 1)) begin
        errors++;
        $display("FAIL tries_count[%0d]: err=%b fc=%0d expected 1/%0d", i, error, fail_count, i + 1);
      end
      if (i < 2) cyc();
    end
    cyc();
`ifdef CODE_LOCK_LOCKOUT_EN
    digit_valid = 1'b1;
    digit       = 4'd1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (lockout !== 1'b1 || state !== 3'd5) begin
        errors++;
        $display("FAIL lockout_hold[%0d]: lko=%b state=%0d expected 1/5", i, lockout, state);
      end
      cyc();
    end
    digit_valid = 1'b0;
    checks++;
    if (state !== 3'd0 || lockout !== 1'b0 || fail_count !== 2'd0) begin
      errors++;
      $display("FAIL lockout_exit: state=%0d lko=%b fc=%0d expected 0/0/0", state, lockout, fail_count);
    end
`else
    checks++;
    if (state !== 3'd0 || lockout !== 1'b0 || fail_count !== 2'd3) begin
      errors++;
      $display("FAIL sat_locked: state=%0d lko=%b fc=%0d expected 0/0/3", state, lockout, fail_count);
    end
    enter_code(16'h9999);
    cyc();
    checks++;
    if (error !== 1'b1 || fail_count !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold: err=%b fc=%0d expected 1/3", error, fail_count);
    end
    cyc();
    enter_code(16'h1234);
    cyc();
    checks++;
    if (unlocked !== 1'b1 || fail_count !== 2'd0) begin
      errors++;
      $display("FAIL sat_recover: unl=%b fc=%0d expected 1/0", unlocked, fail_count);
    end
    do_relock();
`endif
  endtask

  task automatic test_reset_mid();
    enter_code(16'h1111);
    cyc(); cyc();
    send_digit(4'd1);
    send_digit(4'd2);
    send_digit(4'd3);
    checks++;
    if (state !== 3'd1 || fail_count !== 2'd1) begin
      errors++;
      $display("FAIL midreset_pre: state=%0d fc=%0d expected 1/1", state, fail_count);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (state !== 3'd0 || fail_count !== 2'd0) begin
      errors++;
      $display("FAIL midreset_input: state=%0d fc=%0d expected 0/0", state, fail_count);
    end
    enter_code(16'h1234);
    cyc();
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL midreset_unlock: unl=%b expected 1", unlocked); end
    do_relock();
`ifdef CODE_LOCK_LOCKOUT_EN
    for (int i = 0; i < 3; i++) begin
      enter_code(16'h4321);
      cyc(); cyc();
    end
    checks++;
    if (state !== 3'd5) begin errors++; $display("FAIL lockreset_pre: state=%0d expected 5", state); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (state !== 3'd0 || fail_count !== 2'd0 || lockout !== 1'b0) begin
      errors++;
      $display("FAIL lockreset: state=%0d fc=%0d lko=%b expected 0/0/0", state, fail_count, lockout);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_then_right();
    test_clear();
    test_code_sampling();
    test_max_tries();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
